// File: rtl/uart_rx_ext.sv
// UART receiver with parameterised framing, parity and stop-bit checking.
// Define UART_RX_BREAK_DETECT_EN to report all-zero frames as line breaks on rx_break.
module uart_rx_ext #(
  parameter int CLK_HZ    = 200_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break
);

  localparam int          DIV      = CLK_HZ / BAUD;
  localparam logic [15:0] CNT_FULL = 16'(DIV - 1);
  localparam logic [15:0] CNT_HALF = 16'(DIV / 2 - 1);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

`ifdef UART_RX_BREAK_DETECT_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`endif

  state_t               state;
  logic [15:0]          cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_err_q;
  logic                 frame_err_q;

  logic       rxd_meta;
  logic       rxd_s;
  logic       rxd_prev;
  logic [1:0] settle;
  logic       armed;

  logic fall;
  logic par_x;
  logic par_bad;
  logic stop_last;

  // Edge detection is only armed once the synchronizer holds real line samples
  // and the line has been seen high, so a line held low through reset never starts a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
      settle   <= 2'd0;
      armed    <= 1'b0;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
      if (settle != 2'd2)
        settle <= settle + 2'd1;
      if (settle == 2'd2 && rxd_s)
        armed <= 1'b1;
    end
  end

  assign fall      = armed && rxd_prev && !rxd_s;
  assign par_x     = (^shift) ^ rxd_s;
  assign par_bad   = (PARITY == 1) ? ~par_x : par_x;
  assign stop_last = (STOP_BITS == 1) || stop_idx;

`ifdef UART_RX_BREAK_DETECT_EN
  logic all_zero;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      bit_idx       <= 4'd0;
      stop_idx      <= 1'b0;
      shift         <= '0;
      par_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_busy       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      all_zero      <= 1'b0;
      rx_break      <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      rx_break <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            cnt     <= CNT_HALF;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == 16'd0) begin
            if (rxd_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state       <= DATA;
              cnt         <= CNT_FULL;
              bit_idx     <= 4'd0;
              stop_idx    <= 1'b0;
              par_err_q   <= 1'b0;
              frame_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
              all_zero    <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (cnt == 16'd0) begin
            cnt   <= CNT_FULL;
            shift <= {rxd_s, shift[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero <= all_zero & ~rxd_s;
`endif
            if (bit_idx == LAST_BIT)
              state <= (PARITY != 0) ? PAR : STOP;
            else
              bit_idx <= bit_idx + 4'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        PAR: begin
          if (cnt == 16'd0) begin
            cnt       <= CNT_FULL;
            par_err_q <= par_bad;
            state     <= STOP;
`ifdef UART_RX_BREAK_DETECT_EN
            all_zero  <= all_zero & ~rxd_s;
`endif
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        STOP: begin
          if (cnt == 16'd0) begin
            cnt <= CNT_FULL;
            if (stop_last) begin
`ifdef UART_RX_BREAK_DETECT_EN
              if (all_zero && !rxd_s) begin
                rx_break <= 1'b1;
                state    <= BRK;
              end else begin
                state         <= IDLE;
                rx_busy       <= 1'b0;
                rx_valid      <= 1'b1;
                rx_data       <= shift;
                rx_parity_err <= (PARITY != 0) && par_err_q;
                rx_frame_err  <= frame_err_q | ~rxd_s;
              end
`else
              state         <= IDLE;
              rx_busy       <= 1'b0;
              rx_valid      <= 1'b1;
              rx_data       <= shift;
              rx_parity_err <= (PARITY != 0) && par_err_q;
              rx_frame_err  <= frame_err_q | ~rxd_s;
`endif
            end else begin
              stop_idx    <= 1'b1;
              frame_err_q <= frame_err_q | ~rxd_s;
`ifdef UART_RX_BREAK_DETECT_EN
              all_zero    <= all_zero & ~rxd_s;
`endif
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        // Hold off until the line returns high so the break itself is not re-read as a frame.
        BRK: begin
          if (rxd_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
`endif
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef UART_RX_BREAK_DETECT_EN
  assign rx_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: 8N1, 8E1 and 7O2 receivers at DIV=10 on a shared stimulus line.
module tb_uart_rx_ext;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;
  int   sel  = 0;

  logic rxd0, rxd1, rxd2;
  assign rxd0 = (sel == 0) ? line : 1'b1;
  assign rxd1 = (sel == 1) ? line : 1'b1;
  assign rxd2 = (sel == 2) ? line : 1'b1;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, b0, pe0, fe0, br0;
  logic v1, b1, pe1, fe1, br1;
  logic v2, b2, pe2, fe2, br2;

  uart_rx_ext #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
    .clk(clk), .rst(rst), .rxd(rxd0), .rx_data(d0), .rx_valid(v0), .rx_busy(b0),
    .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_break(br0));

  uart_rx_ext #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
    .clk(clk), .rst(rst), .rxd(rxd1), .rx_data(d1), .rx_valid(v1), .rx_busy(b1),
    .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_break(br1));

  uart_rx_ext #(.CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_7o2 (
    .clk(clk), .rst(rst), .rxd(rxd2), .rx_data(d2), .rx_valid(v2), .rx_busy(b2),
    .rx_parity_err(pe2), .rx_frame_err(fe2), .rx_break(br2));

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Strobe monitors sample on the falling edge, away from the active edge.
  int cyc = 0;
  int vcnt0 = 0, vcnt1 = 0, vcnt2 = 0, brcnt0 = 0, busycnt0 = 0, vcyc0 = 0;
  logic [7:0] last_d0 = 8'h00, prev_d0 = 8'h00, last_d1 = 8'h00;
  logic [6:0] last_d2 = 7'h00;
  logic last_pe0 = 1'b0, last_fe0 = 1'b0, last_pe1 = 1'b0, last_fe1 = 1'b0;
  logic last_pe2 = 1'b0, last_fe2 = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (v0) begin
      vcnt0    <= vcnt0 + 1;
      prev_d0  <= last_d0;
      last_d0  <= d0;
      last_pe0 <= pe0;
      last_fe0 <= fe0;
      vcyc0    <= cyc + 1;
    end
    if (br0) brcnt0 <= brcnt0 + 1;
    if (b0) busycnt0 <= busycnt0 + 1;
    if (v1) begin
      vcnt1    <= vcnt1 + 1;
      last_d1  <= d1;
      last_pe1 <= pe1;
      last_fe1 <= fe1;
    end
    if (v2) begin
      vcnt2    <= vcnt2 + 1;
      last_d2  <= d2;
      last_pe2 <= pe2;
      last_fe2 <= fe2;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive n bits LSB-first, ten clocks each, then return the line to idle.
  task automatic apply_stimulus(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      line = bits[i];
      step(10);
    end
    line = 1'b1;
  endtask

  task automatic check_output(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int t0, nv, nbr, bsy;

  initial begin
    step(5);
    rst = 1'b0;
    step(5);

    check_output("reset_data",   int'(d0),  0);
    check_output("reset_valid",  int'(v0),  0);
    check_output("reset_busy",   int'(b0),  0);
    check_output("reset_perr",   int'(pe0), 0);
    check_output("reset_ferr",   int'(fe0), 0);
    check_output("reset_break",  int'(br0), 0);

    // 8N1 0xA5
    sel = 0;
    t0 = cyc;
    apply_stimulus({1'b1, 8'hA5, 1'b0}, 10);
    step(10);
    check_output("a5_count", vcnt0, 1);
    check_output("a5_data",  int'(last_d0), 8'hA5);
    check_output("a5_perr",  int'(last_pe0), 0);
    check_output("a5_ferr",  int'(last_fe0), 0);
    check_output("a5_latency_window", int'((vcyc0 - t0) >= 90 && (vcyc0 - t0) <= 105), 1);

    // 8E1 0x03 with wrong parity bit 1, then 0x07 with correct parity bit 1
    sel = 1;
    apply_stimulus({1'b1, 1'b1, 8'h03, 1'b0}, 11);
    step(10);
    check_output("e03_count", vcnt1, 1);
    check_output("e03_data",  int'(last_d1), 8'h03);
    check_output("e03_perr",  int'(last_pe1), 1);
    check_output("e03_ferr",  int'(last_fe1), 0);
    apply_stimulus({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    step(10);
    check_output("e07_count", vcnt1, 2);
    check_output("e07_data",  int'(last_d1), 8'h07);
    check_output("e07_perr",  int'(last_pe1), 0);

    // 7O2 0x41, correct odd parity 1, second stop bit 0
    sel = 2;
    apply_stimulus({1'b0, 1'b1, 1'b1, 7'h41, 1'b0}, 11);
    step(10);
    check_output("o41_count", vcnt2, 1);
    check_output("o41_data",  int'(last_d2), 7'h41);
    check_output("o41_ferr",  int'(last_fe2), 1);
    check_output("o41_perr",  int'(last_pe2), 0);

    // 3-cycle low glitch
    sel = 0;
    bsy = busycnt0;
    line = 1'b0;
    step(3);
    line = 1'b1;
    step(30);
    check_output("glitch_no_strobe", vcnt0, 1);
    check_output("glitch_busy_seen", int'((busycnt0 - bsy) >= 1), 1);
    check_output("glitch_busy_short", int'((busycnt0 - bsy) <= 8), 1);
    check_output("glitch_idle", int'(b0), 0);

    // Break: start + 8 zero data bits + 20 bit-times low
    nv = vcnt0;
    nbr = brcnt0;
    line = 1'b0;
    step(290);
    line = 1'b1;
    step(30);
`ifdef UART_RX_BREAK_DETECT_EN
    check_output("break_strobe", brcnt0, nbr + 1);
    check_output("break_no_valid", vcnt0, nv);
`else
    check_output("break_valid", vcnt0, nv + 1);
    check_output("break_data", int'(last_d0), 0);
    check_output("break_ferr", int'(last_fe0), 1);
    check_output("break_no_brk", brcnt0, nbr);
`endif
    check_output("break_idle", int'(b0), 0);
    nv = vcnt0;
    apply_stimulus({1'b1, 8'h55, 1'b0}, 10);
    step(10);
    check_output("post_break_count", vcnt0, nv + 1);
    check_output("post_break_data", int'(last_d0), 8'h55);
    check_output("post_break_ferr", int'(last_fe0), 0);

    // Back-to-back 0x12, 0x34, reset during the third frame while the line is low
    nv = vcnt0;
    apply_stimulus({1'b1, 8'h12, 1'b0}, 10);
    apply_stimulus({1'b1, 8'h34, 1'b0}, 10);
    line = 1'b0;
    step(15);
    rst = 1'b1;
    step(3);
    check_output("rst_mid_busy", int'(b0), 0);
    rst = 1'b0;
    step(30);
    line = 1'b1;
    step(60);
    check_output("b2b_count", vcnt0, nv + 2);
    check_output("b2b_first", int'(prev_d0), 8'h12);
    check_output("b2b_second", int'(last_d0), 8'h34);
    check_output("post_rst_data",  int'(d0),  0);
    check_output("post_rst_valid", int'(v0),  0);
    check_output("post_rst_busy",  int'(b0),  0);
    check_output("post_rst_perr",  int'(pe0), 0);
    check_output("post_rst_ferr",  int'(fe0), 0);
    check_output("post_rst_break", int'(br0), 0);

    // Reception resumes on a fresh edge
    apply_stimulus({1'b1, 8'h5A, 1'b0}, 10);
    step(10);
    check_output("resume_count", vcnt0, nv + 3);
    check_output("resume_data", int'(last_d0), 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
